alu_issue_unit: RTL and testbench
=================================

# alu_issue_unit

Operand-fetch and write-back stage that feeds the 8-bit combinational ALU. It accepts one 20-bit instruction at a time over a valid/ready handshake and reads two operands from an internal 8x8-bit register file. It drives the ALU's `a`, `b` and `sel` inputs, captures `res` and `zeroFlag`, and writes the result back to the register file. Opcode 111, which the ALU does not use, is handled locally as load-immediate.

## Interface
- `NREGS`, default 8: register-file depth. Fixed at 8 because the register fields are 3 bits wide.
- `W`, default 8: data width. Matches the ALU.
- `clk`  in  1: single clock, rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `instr`  in  20: bits [19:17] op, [16:14] rd, [13:11] rs1, [10:8] rs2, [7:0] imm.
- `instr_valid`  in  1: `instr` is valid.
- `instr_ready`  out  1: the unit can accept an instruction.
- `alu_a`  out  8: operand A to the ALU `a` input. Registered.
- `alu_b`  out  8: operand B to the ALU `b` input. Registered.
- `alu_sel`  out  3: operation select to the ALU `sel` input. Registered.
- `alu_res`  in  8: ALU result.
- `alu_zero`  in  1: ALU `zeroFlag`.
- `wb_valid`  out  1: one-cycle pulse when a register write happens.
- `wb_addr`  out  3: destination register of the write flagged by `wb_valid`.
- `wb_data`  out  8: value written in that same write.
- `zero_flag`  out  1: zero status of the last completed instruction. Sticky until the next write-back.
- `dbg_addr`  in  3: debug read address.
- `dbg_data`  out  8: combinational read of `regs[dbg_addr]`.

## Operation
- FSM states: IDLE, EXEC, WB. Reset state is IDLE.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid`&&`instr_ready`, latch op, rd and imm.
  - Load `alu_a`<=`regs[rs1]`, `alu_b`<=`regs[rs2]`, `alu_sel`<=op.
  - Go to EXEC.
  - With no valid instruction, stay in IDLE. All registered outputs hold their values.
- EXEC:
  - `instr_ready`=0.
  - The ALU settles combinationally on the registered operands.
  - Go to WB unconditionally.
- WB:
  - `instr_ready`=0.
  - op != 111: `regs[rd]`<=`alu_res`, `zero_flag`<=`alu_zero`.
  - op == 111 (LOADI): `regs[rd]`<=imm, `zero_flag`<=(imm==0). `alu_res`/`alu_zero` are ignored.
  - Pulse `wb_valid`=1 for one cycle with `wb_addr`=rd and `wb_data`=the written value.
  - Go to IDLE.
- Operands are read from the register file in the acceptance cycle, so rd==rs1 or rd==rs2 reads the old value.
- Instructions never overlap, so no forwarding or hazard logic exists.
- Op encoding matches the ALU: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 NAND, 111 LOADI.
- Arithmetic is the ALU's; results are truncated to 8 bits by the ALU. This unit does no width extension.
- DIV by zero is passed to the ALU unchanged; whatever `alu_res` it returns is written back.
- An `instr_valid` held high while busy is not consumed. The source must hold `instr` stable until `instr_ready` is high.
- Register writes happen only in WB. `dbg_data` shows the new value from the cycle after WB.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - All regs, `alu_a`, `alu_b`, `alu_sel`, `wb_addr`, `wb_data`, `wb_valid` and `zero_flag` go to 0.
  - State goes to IDLE, so `instr_ready`=1 once reset is released.
- Reset asserted in EXEC or WB aborts the instruction. No write occurs and no `wb_valid` pulse is issued.
- Latency: handshake at edge N. `alu_*` are valid after N. EXEC occupies cycle N+1. `wb_valid` is high during cycle N+2, and the register is updated at the end of N+2.
- Throughput: one instruction per 3 cycles. `instr_ready` rises in the cycle after WB.
- `zero_flag` changes only at the WB edge.

## Test plan
- Reset: assert `rst_n`=0 mid-EXEC -> all outputs 0, `instr_ready`=1 after release, `dbg_data`=0 for every address, no `wb_valid`.
- LOADI r1=4 and r2=100, then ADD r3=r1+r2 -> `alu_a`=4, `alu_b`=100, `alu_sel`=000; WB pulse with `wb_addr`=3, `wb_data`=104; `zero_flag`=0; `dbg_data`(3)=104.
- LOADI r4=10, then SUB r5=r4-r4 -> `wb_data`=0, `zero_flag`=1. A following LOADI r6=7 clears `zero_flag` to 0.
- Handshake: hold `instr_valid`=1 continuously with two instructions -> exactly 3 cycles between acceptances, `instr_ready` low for 2 cycles after each, second instruction accepted only in IDLE.
- Aliasing: r1=20, MUL r1=r1*r1 -> `alu_a`=`alu_b`=20, written value 144 (400 mod 256).
- Logic ops: r1=122, r2=100: AND -> 96, NAND -> 159. r1=232, r2=111: OR -> 239.

Source files
------------

// File: rtl/alu_issue_unit.sv
// Operand-fetch / write-back stage wrapped around an external 8-bit combinational ALU.
// Holds an 8x8 register file, issues one instruction every three cycles and handles LOADI locally.
module alu_issue_unit #(
    parameter int NREGS = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [19:0]  instr,
    input  logic         instr_valid,
    output logic         instr_ready,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_sel,
    input  logic [W-1:0] alu_res,
    input  logic         alu_zero,
    output logic         wb_valid,
    output logic [2:0]   wb_addr,
    output logic [W-1:0] wb_data,
    output logic         zero_flag,
    input  logic [2:0]   dbg_addr,
    output logic [W-1:0] dbg_data
);

    localparam logic [2:0] OP_LOADI = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [W-1:0] regs [NREGS];
    logic [2:0]   op_reg;
    logic [W-1:0] imm_reg;
    logic         wb_zero_reg;
    logic         accept;
    logic [NREGS-1:0] reg_we;

    logic [2:0]   f_op, f_rd, f_rs1, f_rs2;
    logic [W-1:0] f_imm;

    assign f_op   = instr[19:17];
    assign f_rd   = instr[16:14];
    assign f_rs1  = instr[13:11];
    assign f_rs2  = instr[10:8];
    assign f_imm  = instr[7:0];
    assign accept = instr_valid && instr_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        instr_ready = (state_reg == IDLE);
    end

    // Operand fetch in the acceptance cycle; rd==rs aliasing therefore sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            op_reg  <= '0;
            imm_reg <= '0;
            wb_addr <= '0;
        end else if (accept) begin
            alu_a   <= regs[f_rs1];
            alu_b   <= regs[f_rs2];
            alu_sel <= f_op;
            op_reg  <= f_op;
            imm_reg <= f_imm;
            wb_addr <= f_rd;
        end
    end

    // The write-back value is captured at the end of EXEC so it is visible throughout WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_zero_reg <= 1'b0;
            zero_flag   <= 1'b0;
        end else begin
            wb_valid <= (state_reg == EXEC);
            if (state_reg == EXEC) begin
                if (op_reg == OP_LOADI) begin
                    wb_data     <= imm_reg;
                    wb_zero_reg <= (imm_reg == '0);
                end else begin
                    wb_data     <= alu_res;
                    wb_zero_reg <= alu_zero;
                end
            end
            if (state_reg == WB) begin
                zero_flag <= wb_zero_reg;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_we
            assign reg_we[gi] = (state_reg == WB) && (wb_addr == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (reg_we[i]) begin
                    regs[i] <= wb_data;
                end
            end
        end
    end

    assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: a behavioural ALU closes the loop and every
// instruction is checked at acceptance, EXEC, WB and the following IDLE cycle.
module tb_alu_issue_unit;

    logic        clk;
    logic        rst_n;
    logic [19:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_sel;
    logic [7:0]  alu_res;
    logic        alu_zero;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [7:0]  wb_data;
    logic        zero_flag;
    logic [2:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_q [$];
    int wb_seen = 0;

    alu_issue_unit #(.NREGS(8), .W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_res    (alu_res),
        .alu_zero   (alu_zero),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .zero_flag  (zero_flag),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; sel 111 deliberately returns 0/zero so a LOADI that used it would show.
    always_comb begin
        alu_res = 8'h00;
        case (alu_sel)
            3'b000: alu_res = alu_a + alu_b;
            3'b001: alu_res = alu_a - alu_b;
            3'b010: alu_res = alu_a * alu_b;
            3'b011: alu_res = (alu_b == 8'h00) ? 8'hFF : alu_a / alu_b;
            3'b100: alu_res = alu_a & alu_b;
            3'b101: alu_res = alu_a | alu_b;
            3'b110: alu_res = ~(alu_a & alu_b);
            default: alu_res = 8'h00;
        endcase
        alu_zero = (alu_res == 8'h00);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (instr_valid && instr_ready) acc_q.push_back(cyc);
        if (wb_valid) wb_seen <= wb_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic [7:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic run_instr(input string name, input logic [2:0] op, input logic [2:0] rd,
                             input logic [2:0] rs1, input logic [2:0] rs2, input logic [7:0] imm,
                             input logic [7:0] exp_a, input logic [7:0] exp_b,
                             input logic [7:0] exp_wb, input logic exp_z);
        @(negedge clk);
        instr       = mk(op, rd, rs1, rs2, imm);
        instr_valid = 1'b1;
        check({name, ".ready_idle"}, instr_ready, 1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check({name, ".alu_a"}, alu_a, exp_a);
        check({name, ".alu_b"}, alu_b, exp_b);
        check({name, ".alu_sel"}, alu_sel, op);
        check({name, ".ready_exec"}, instr_ready, 0);
        check({name, ".wbv_exec"}, wb_valid, 0);
        @(posedge clk);
        #1;
        check({name, ".wbv_wb"}, wb_valid, 1);
        check({name, ".wb_addr"}, wb_addr, rd);
        check({name, ".wb_data"}, wb_data, exp_wb);
        check({name, ".ready_wb"}, instr_ready, 0);
        @(posedge clk);
        #1;
        check({name, ".wbv_after"}, wb_valid, 0);
        check({name, ".zero_flag"}, zero_flag, exp_z);
        check({name, ".ready_after"}, instr_ready, 1);
        dbg_addr = rd;
        #1;
        check({name, ".dbg"}, dbg_data, exp_wb);
        $display("instr %s op=%0d rd=%0d rs1=%0d rs2=%0d imm=%0d -> wb=%0d z=%0d",
                 name, op, rd, rs1, rs2, imm, wb_data, zero_flag);
    endtask

    initial begin
        int wb_before;
        int t0;
        int waited;
        rst_n       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        dbg_addr    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.ready", instr_ready, 1);
        check("rst.alu_a", alu_a, 0);
        check("rst.alu_b", alu_b, 0);
        check("rst.alu_sel", alu_sel, 0);
        check("rst.wb_valid", wb_valid, 0);
        check("rst.wb_addr", wb_addr, 0);
        check("rst.wb_data", wb_data, 0);
        check("rst.zero_flag", zero_flag, 0);
        $display("reset released");

        // Give a register a nonzero value, then abort a second instruction mid-EXEC.
        run_instr("ld_r1", 3'b111, 3'd1, 3'd0, 3'd0, 8'd4, 8'd0, 8'd0, 8'd4, 1'b0);
        run_instr("ld_r5", 3'b111, 3'd5, 3'd0, 3'd0, 8'd77, 8'd0, 8'd0, 8'd77, 1'b0);
        run_instr("add_r2", 3'b000, 3'd2, 3'd1, 3'd5, 8'd0, 8'd4, 8'd77, 8'd81, 1'b0);
        @(negedge clk);
        instr       = mk(3'b111, 3'd2, 3'd1, 3'd5, 8'd9);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        wb_before   = wb_seen;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.alu_a", alu_a, 0);
        check("abort.alu_b", alu_b, 0);
        check("abort.alu_sel", alu_sel, 0);
        check("abort.wb_valid", wb_valid, 0);
        check("abort.wb_data", wb_data, 0);
        check("abort.zero_flag", zero_flag, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort.no_wb", wb_seen - wb_before, 0);
        check("abort.ready", instr_ready, 1);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check($sformatf("abort.dbg%0d", i), dbg_data, 0);
        end
        $display("reset during EXEC done");

        run_instr("ld_r1_4", 3'b111, 3'd1, 3'd0, 3'd0, 8'd4, 8'd0, 8'd0, 8'd4, 1'b0);
        run_instr("ld_r2_100", 3'b111, 3'd2, 3'd0, 3'd0, 8'd100, 8'd0, 8'd0, 8'd100, 1'b0);
        run_instr("add_r3", 3'b000, 3'd3, 3'd1, 3'd2, 8'd0, 8'd4, 8'd100, 8'd104, 1'b0);

        run_instr("ld_r4_10", 3'b111, 3'd4, 3'd0, 3'd0, 8'd10, 8'd0, 8'd0, 8'd10, 1'b0);
        run_instr("sub_r5", 3'b001, 3'd5, 3'd4, 3'd4, 8'd0, 8'd10, 8'd10, 8'd0, 1'b1);
        run_instr("ld_r6_7", 3'b111, 3'd6, 3'd0, 3'd0, 8'd7, 8'd0, 8'd0, 8'd7, 1'b0);
        run_instr("ld_r7_0", 3'b111, 3'd7, 3'd0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);

        // Back-to-back: instr_valid held high across two instructions.
        acc_q.delete();
        @(negedge clk);
        instr       = mk(3'b111, 3'd6, 3'd0, 3'd0, 8'd55);
        instr_valid = 1'b1;
        waited = 0;
        while (acc_q.size() < 1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("hs.first_accept", acc_q.size(), 1);
        instr = mk(3'b111, 3'd7, 3'd0, 3'd0, 8'd66);
        @(negedge clk);
        check("hs.ready_low1", instr_ready, 0);
        @(negedge clk);
        check("hs.ready_low2", instr_ready, 0);
        @(negedge clk);
        check("hs.ready_high", instr_ready, 1);
        waited = 0;
        while (acc_q.size() < 2 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        instr_valid = 1'b0;
        check("hs.second_accept", acc_q.size(), 2);
        t0 = (acc_q.size() >= 2) ? acc_q[1] - acc_q[0] : -1;
        check("hs.spacing", 32'(t0), 3);
        repeat (4) @(posedge clk);
        #1;
        check("hs.accept_count", acc_q.size(), 2);
        dbg_addr = 3'd6;
        #1;
        check("hs.dbg_r6", dbg_data, 55);
        dbg_addr = 3'd7;
        #1;
        check("hs.dbg_r7", dbg_data, 66);
        $display("handshake spacing=%0d accepts=%0d", t0, acc_q.size());

        run_instr("ld_r1_20", 3'b111, 3'd1, 3'd0, 3'd0, 8'd20, 8'd0, 8'd0, 8'd20, 1'b0);
        run_instr("mul_alias", 3'b010, 3'd1, 3'd1, 3'd1, 8'd0, 8'd20, 8'd20, 8'd144, 1'b0);

        run_instr("ld_r1_122", 3'b111, 3'd1, 3'd0, 3'd0, 8'd122, 8'd0, 8'd0, 8'd122, 1'b0);
        run_instr("ld_r2_100b", 3'b111, 3'd2, 3'd0, 3'd0, 8'd100, 8'd0, 8'd0, 8'd100, 1'b0);
        run_instr("and_r3", 3'b100, 3'd3, 3'd1, 3'd2, 8'd0, 8'd122, 8'd100, 8'd96, 1'b0);
        run_instr("nand_r3", 3'b110, 3'd3, 3'd1, 3'd2, 8'd0, 8'd122, 8'd100, 8'd159, 1'b0);
        run_instr("ld_r1_232", 3'b111, 3'd1, 3'd0, 3'd0, 8'd232, 8'd0, 8'd0, 8'd232, 1'b0);
        run_instr("ld_r2_111", 3'b111, 3'd2, 3'd0, 3'd0, 8'd111, 8'd0, 8'd0, 8'd111, 1'b0);
        run_instr("or_r3", 3'b101, 3'd3, 3'd1, 3'd2, 8'd0, 8'd232, 8'd111, 8'd239, 1'b0);
        run_instr("div_r4", 3'b011, 3'd4, 3'd1, 3'd2, 8'd0, 8'd232, 8'd111, 8'd2, 1'b0);
        run_instr("div0_r5", 3'b011, 3'd5, 3'd1, 3'd0, 8'd0, 8'd232, 8'd0, 8'd255, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
